// File: rtl/fft_stage_counter.sv
// Butterfly sequencer for the shared-butterfly FFT.
// It walks every butterfly index of every radix-2 stage for a run-time length,
// and decodes the DIT twiddle address and the terminal flags for the address generators.
module fft_stage_counter #(
    parameter int unsigned MAX_LOG2N = 13,
    parameter int unsigned STAGE_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [STAGE_W-1:0]   log2n,
    input  logic                 en,
    input  logic                 abort,
    output logic                 busy,
    output logic [MAX_LOG2N-2:0] idx,
    output logic [STAGE_W-1:0]   stage,
    output logic [MAX_LOG2N-2:0] tw_addr,
    output logic                 last_in_stage,
    output logic                 last,
    output logic                 done,
    output logic                 cfg_err
);

    localparam int unsigned IW = MAX_LOG2N - 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [STAGE_W-1:0] len_q, len_d;
    logic               done_q, done_d;
    logic               cfg_err_q, cfg_err_d;

    logic [IW-1:0]      half_m1;
    logic [STAGE_W-1:0] half_shift;
    logic [STAGE_W-1:0] tw_shift;
    logic [IW-1:0]      stage_mask;
    logic               is_last_idx;
    logic               is_last_stage;
    logic               log2n_ok;

    // Decode per-length limits and the twiddle address from the registered state.
    always_comb begin
        // HALF-1 is a right-shifted all-ones mask, so the wrap never depends on a carry-out.
        half_shift    = STAGE_W'(MAX_LOG2N) - len_q;
        half_m1       = {IW{1'b1}} >> half_shift;
        is_last_idx   = (idx_q == half_m1);
        is_last_stage = (stage_q == len_q - STAGE_W'(1));
        stage_mask    = ~({IW{1'b1}} << stage_q);
        tw_shift      = len_q - STAGE_W'(1) - stage_q;
        log2n_ok      = (log2n != '0) && (log2n <= STAGE_W'(MAX_LOG2N));

        busy          = (state_q == StRun);
        idx           = idx_q;
        stage         = stage_q;
        last_in_stage = busy & is_last_idx;
        last          = last_in_stage & is_last_stage;
        tw_addr       = busy ? ((idx_q & stage_mask) << tw_shift) : '0;
        done          = done_q;
        cfg_err       = cfg_err_q;
    end

    // Next-state logic for the run FSM and the index/stage counters.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        stage_d   = stage_q;
        len_d     = len_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (log2n_ok) begin
                        len_d   = log2n;
                        idx_d   = '0;
                        stage_d = '0;
                        state_d = StRun;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                // abort wins over en; start is ignored so L stays fixed for the whole run.
                if (abort) begin
                    state_d = StIdle;
                    idx_d   = '0;
                    stage_d = '0;
                end else if (en) begin
                    if (!is_last_idx) begin
                        idx_d = idx_q + IW'(1);
                    end else if (!is_last_stage) begin
                        idx_d   = '0;
                        stage_d = stage_q + STAGE_W'(1);
                    end else begin
                        idx_d   = '0;
                        stage_d = '0;
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            stage_q   <= '0;
            len_q     <= STAGE_W'(1);
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            stage_q   <= stage_d;
            len_q     <= len_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_fft_stage_counter.sv
// Directed self-checking bench for fft_stage_counter.
module tb_fft_stage_counter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  log2n;
    logic        en;
    logic        abort;
    logic        busy;
    logic [11:0] idx;
    logic [3:0]  stage;
    logic [11:0] tw_addr;
    logic        last_in_stage;
    logic        last;
    logic        done;
    logic        cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    fft_stage_counter #(
        .MAX_LOG2N (13),
        .STAGE_W   (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .log2n         (log2n),
        .en            (en),
        .abort         (abort),
        .busy          (busy),
        .idx           (idx),
        .stage         (stage),
        .tw_addr       (tw_addr),
        .last_in_stage (last_in_stage),
        .last          (last),
        .done          (done),
        .cfg_err       (cfg_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " idx"}, 32'(idx), 0);
        check({tag, " stage"}, 32'(stage), 0);
        check({tag, " tw"}, 32'(tw_addr), 0);
        check({tag, " last"}, 32'(last), 0);
        check({tag, " lis"}, 32'(last_in_stage), 0);
    endtask

    initial begin
        int tw3[12];
        int adv;
        int cycles;
        int hold_err;
        logic [11:0] p_idx;
        logic [3:0]  p_stage;

        tw3 = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
        rst = 1'b1; start = 1'b0; log2n = '0; en = 1'b0; abort = 1'b0;
        #1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_idle("reset");
        check("reset done", 32'(done), 0);
        check("reset cfg_err", 32'(cfg_err), 0);

        // log2n=3 with en held high
        start = 1'b1; log2n = 4'd3;
        tick();
        start = 1'b0;
        check("l3 busy", 32'(busy), 1);
        en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            check($sformatf("l3 idx a%0d", k), 32'(idx), (k - 1) % 4);
            check($sformatf("l3 stage a%0d", k), 32'(stage), (k - 1) / 4);
            check($sformatf("l3 tw a%0d", k), 32'(tw_addr), tw3[k-1]);
            check($sformatf("l3 lis a%0d", k), 32'(last_in_stage), ((k - 1) % 4 == 3) ? 1 : 0);
            check($sformatf("l3 last a%0d", k), 32'(last), (k == 12) ? 1 : 0);
            check($sformatf("l3 done a%0d", k), 32'(done), 0);
            tick();
        end
        en = 1'b0;
        check("l3 done", 32'(done), 1);
        check("l3 busy end", 32'(busy), 0);
        tick();
        check("l3 done low", 32'(done), 0);

        // log2n=13, en randomly gated, idx must hold when en=0
        start = 1'b1; log2n = 4'd13;
        tick();
        start = 1'b0;
        adv = 0; cycles = 0; hold_err = 0;
        while (busy && cycles < 80000) begin
            en = ($urandom_range(0, 7) != 0);
            p_idx = idx;
            p_stage = stage;
            tick();
            cycles++;
            if (en) adv++;
            else if (idx !== p_idx || stage !== p_stage) hold_err++;
        end
        en = 1'b0;
        check("l13 advances", adv, 53248);
        check("l13 done", 32'(done), 1);
        check("l13 hold", hold_err, 0);
        tick();

        // Rejected lengths
        start = 1'b1; log2n = 4'd0;
        tick();
        start = 1'b0;
        check("l0 cfg_err", 32'(cfg_err), 1);
        check_idle("l0");
        tick();
        check("l0 cfg_err low", 32'(cfg_err), 0);
        start = 1'b1; log2n = 4'd14;
        tick();
        start = 1'b0;
        check("l14 cfg_err", 32'(cfg_err), 1);
        check_idle("l14");
        tick();
        check("l14 cfg_err low", 32'(cfg_err), 0);

        // log2n=1: single-butterfly run
        start = 1'b1; log2n = 4'd1;
        tick();
        start = 1'b0;
        check("l1 busy", 32'(busy), 1);
        check("l1 last", 32'(last), 1);
        check("l1 lis", 32'(last_in_stage), 1);
        en = 1'b1;
        tick();
        en = 1'b0;
        check("l1 done", 32'(done), 1);
        check("l1 busy end", 32'(busy), 0);
        tick();

        // Abort at stage 2, idx 5 of log2n=4
        start = 1'b1; log2n = 4'd4;
        tick();
        start = 1'b0;
        en = 1'b1;
        repeat (21) tick();
        en = 1'b0;
        check("ab stage", 32'(stage), 2);
        check("ab idx", 32'(idx), 5);
        check("ab tw", 32'(tw_addr), 2);
        abort = 1'b1; en = 1'b1;
        tick();
        abort = 1'b0; en = 1'b0;
        check_idle("ab");
        check("ab done", 32'(done), 0);
        tick();
        check("ab done later", 32'(done), 0);
        start = 1'b1; log2n = 4'd4;
        tick();
        start = 1'b0;
        check("ab restart busy", 32'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // rst mid-run at log2n=5
        start = 1'b1; log2n = 4'd5;
        tick();
        start = 1'b0;
        en = 1'b1;
        repeat (7) tick();
        check("rst pre idx", 32'(idx), 7);
        rst = 1'b1;
        tick();
        rst = 1'b0; en = 1'b0;
        check_idle("rst");
        check("rst done", 32'(done), 0);
        check("rst cfg_err", 32'(cfg_err), 0);
        tick();
        check("rst done later", 32'(done), 0);

        // start during RUN is ignored; start in the done cycle is accepted
        start = 1'b1; log2n = 4'd5;
        tick();
        log2n = 4'd2;
        en = 1'b1;
        repeat (79) tick();
        check("sr busy", 32'(busy), 1);
        check("sr stage", 32'(stage), 4);
        check("sr idx", 32'(idx), 15);
        check("sr last", 32'(last), 1);
        tick();
        check("sr done", 32'(done), 1);
        check("sr busy end", 32'(busy), 0);
        tick();
        start = 1'b0; en = 1'b0;
        check("sr b2b busy", 32'(busy), 1);
        check("sr b2b idx", 32'(idx), 0);
        check("sr b2b done", 32'(done), 0);
        check("sr b2b lis", 32'(last_in_stage), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
